// File: rtl/csync_scandoubler.sv
// Composite-sync scan doubler: each source line is captured into one half of a
// two-line buffer while the other half is replayed twice at the output rate.
module csync_scandoubler #(
  parameter int unsigned DW         = 1,
  parameter int unsigned LINE_LEN   = 414,
  parameter int unsigned VS_THRESH  = 80,
  parameter int unsigned HS_START   = 384,
  parameter int unsigned HDE_START  = 64,
  parameter int unsigned HDE_END    = 364,
  parameter int unsigned VDE_START  = 16,
  parameter int unsigned VDE_END    = 272,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic [DW-1:0] video_in,
  input  logic          csync_in,
  input  logic          invert,
  output logic [DW-1:0] video_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          de_out,
  output logic          resync,
  output logic          locked,
  output logic [9:0]    line_cnt
);

  localparam int unsigned      LockW   = $clog2(LOCK_LINES + 1);
  localparam logic [8:0]       LastCol = 9'(LINE_LEN - 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_LINES);

  logic             cs_q;
  logic [7:0]       sync_len_q, sync_len_d;
  logic [9:0]       in_col_q, in_col_d;
  logic [8:0]       out_col_q, out_col_d;
  logic [9:0]       line_q, line_d;
  logic             bank_q, bank_d;
  logic             vs_q, vs_d;
  logic [LockW-1:0] lock_q, lock_d;
  logic             armed_q, armed_d;
  logic [DW-1:0]    video_q, video_d;
  logic             hs_q, hs_d;
  logic             de_q, de_d;
  logic             resync_q, resync_d;

  logic             rise, hs_edge, vs_hit;
  logic             h_de, v_de;
  logic [DW-1:0]    rd_data;
  logic [DW-1:0]    mem [1024];

  always_comb begin
    rise    = csync_in & ~cs_q;
    hs_edge = rise & (sync_len_q < 8'(VS_THRESH));
    vs_hit  = ~csync_in & (sync_len_q == 8'(VS_THRESH));

    if (csync_in) begin
      sync_len_d = '0;
    end else if (sync_len_q != 8'hff) begin
      sync_len_d = sync_len_q + 8'd1;
    end else begin
      sync_len_d = sync_len_q;
    end

    vs_d = vs_q;
    if (vs_hit) begin
      vs_d = 1'b1;
    end else if (csync_in) begin
      vs_d = 1'b0;
    end

    // A line-count increment wins over a vsync reload on the same clock.
    line_d = line_q;
    if (rise) begin
      if (line_q != 10'h3ff) line_d = line_q + 10'd1;
    end else if (vs_hit) begin
      line_d = '0;
    end

    bank_d = bank_q ^ rise;

    if (hs_edge) begin
      in_col_d  = '0;
      out_col_d = '0;
    end else begin
      in_col_d  = (in_col_q == 10'h3ff) ? in_col_q : in_col_q + 10'd1;
      out_col_d = (out_col_q == LastCol) ? 9'd0 : out_col_q + 9'd1;
    end

    // An edge landing exactly where the output line would wrap anyway is in phase.
    resync_d = hs_edge & (out_col_q != LastCol);
    lock_d   = lock_q;
    if (resync_d) begin
      lock_d = '0;
    end else if (hs_edge && (lock_q != LockMax)) begin
      lock_d = lock_q + LockW'(1);
    end

    armed_d = armed_q | hs_edge;
  end

  always_comb begin
    h_de    = (out_col_q >= 9'(HDE_START)) && (out_col_q < 9'(HDE_END));
    v_de    = (line_q >= 10'(VDE_START)) && (line_q < 10'(VDE_END));
    de_d    = h_de & v_de;
    hs_d    = armed_q & (out_col_q >= 9'(HS_START));
    rd_data = mem[{~bank_q, out_col_q}];
    video_d = de_d ? (rd_data ^ {DW{invert}}) : '0;
  end

  // Buffer contents survive reset; only the pointers and outputs are cleared.
  always_ff @(posedge clk) begin
    if (in_col_q[0]) mem[{bank_q, in_col_q[9:1]}] <= video_in;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cs_q       <= 1'b0;
      sync_len_q <= '0;
      in_col_q   <= '0;
      out_col_q  <= '0;
      line_q     <= '0;
      bank_q     <= 1'b0;
      vs_q       <= 1'b0;
      lock_q     <= '0;
      armed_q    <= 1'b0;
      video_q    <= '0;
      hs_q       <= 1'b0;
      de_q       <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      cs_q       <= csync_in;
      sync_len_q <= sync_len_d;
      in_col_q   <= in_col_d;
      out_col_q  <= out_col_d;
      line_q     <= line_d;
      bank_q     <= bank_d;
      vs_q       <= vs_d;
      lock_q     <= lock_d;
      armed_q    <= armed_d;
      video_q    <= video_d;
      hs_q       <= hs_d;
      de_q       <= de_d;
      resync_q   <= resync_d;
    end
  end

  assign video_out = video_q;
  assign hs_out    = hs_q;
  assign vs_out    = vs_q;
  assign de_out    = de_q;
  assign resync    = resync_q;
  assign locked    = (lock_q == LockMax);
  assign line_cnt  = line_q;

endmodule
